// File: rtl/median_pkg.sv
// median_pkg: shared types and constants for the median threshold search.
// Contents: FSM state enum, default lane count, sigma scaling constants
// (median/0.6745 ~= median*24290>>14) and a counter-width helper.
// Optional feature macro used by the consumers: MEDIAN_SIGMA_EN.
package median_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISCARD,
    MEASURE,
    UPDATE,
    DONE
  } state_t;

  localparam int unsigned LANES_DEFAULT = 8;
  localparam int unsigned SIGMA_MULT    = 24290;
  localparam int unsigned SIGMA_SHIFT   = 14;

  // Width needed to hold a count of 0..max_window samples.
  function automatic int unsigned cnt_width(input int unsigned max_window);
    return $clog2(max_window) + 1;
  endfunction

endpackage

// File: rtl/median_sar_lane.sv
// median_sar_lane: one lane of the successive-approximation median search.
// Holds the lane result, the captured "samples below level" count, the
// trial-level register, the rank compare and the sigma estimate path.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   init            accepted start: clear result, load first trial level
//   capture         latch count for the decision
//   update          apply the decision for bit bit_idx
//   last            bit_idx is 0 (final iteration)
//   bit_idx         current bit under test
//   rank_k          target rank K
//   count           samples strictly below level in the measured window
//   level           trial level driven to the counter bank
//   median, sigma   final result and noise-sigma estimate
// Macro MEDIAN_SIGMA_EN: sigma = sat((median*24290)>>14); else sigma = median.
module median_sar_lane
  import median_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 14,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned BIT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 capture,
  input  logic                 update,
  input  logic                 last,
  input  logic [BIT_W-1:0]     bit_idx,
  input  logic [CNT_W-1:0]     rank_k,
  input  logic [CNT_W-1:0]     count,
  output logic [ADC_WIDTH-1:0] level,
  output logic [ADC_WIDTH-1:0] median,
  output logic [ADC_WIDTH-1:0] sigma
);

  logic [ADC_WIDTH-1:0] result;
  logic [ADC_WIDTH-1:0] result_next;
  logic [ADC_WIDTH-1:0] bit_mask;
  logic [ADC_WIDTH-1:0] next_mask;
  logic [ADC_WIDTH-1:0] sigma_next;
  logic [CNT_W-1:0]     count_q;

  // Fewer than K samples below the trial means the K-th smallest is >= trial.
  assign bit_mask    = ADC_WIDTH'(1) << bit_idx;
  assign next_mask   = bit_mask >> 1;
  assign result_next = (count_q < rank_k) ? (result | bit_mask) : result;

`ifdef MEDIAN_SIGMA_EN
  localparam int unsigned PROD_W = ADC_WIDTH + 15;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] scaled;

  // sigma ~= median / 0.6745, saturated to full scale.
  assign product    = PROD_W'(result_next) * PROD_W'(SIGMA_MULT);
  assign scaled     = product >> SIGMA_SHIFT;
  assign sigma_next = (scaled > PROD_W'({ADC_WIDTH{1'b1}})) ? '1 : scaled[ADC_WIDTH-1:0];
`else
  assign sigma_next = result_next;
`endif

  // Result, count capture and trial-level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      count_q <= '0;
      level   <= '0;
      median  <= '0;
      sigma   <= '0;
    end else begin
      if (init) begin
        result <= '0;
        level  <= ADC_WIDTH'(1) << (ADC_WIDTH - 1);
      end
      if (capture) begin
        count_q <= count;
      end
      if (update) begin
        result <= result_next;
        if (last) begin
          median <= result_next;
          sigma  <= sigma_next;
          level  <= '0;
        end else begin
          level  <= result_next | next_mask;
        end
      end
    end
  end

endmodule

// File: rtl/median_threshold_search.sv
// median_threshold_search: per-lane SAR median search against a window
// counter bank. Drives a trial level per lane, discards the first (mixed)
// window after each level change, decides one bit per measured window, and
// reports the K-th smallest magnitude (K = ceil(N/2)) per lane.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin a search (honoured only in IDLE)
//   window_size_cfg   window length minus one, latched on start
//   count_valid_i     counter-bank window end pulse
//   count_i           per-lane counts of samples below level_o
//   level_o           per-lane trial level
//   search_en_o       counter bank enable (all non-IDLE states)
//   busy_o            search in progress
//   median_o, sigma_o per-lane median and noise-sigma estimate
//   median_valid_o    one-cycle pulse when median_o/sigma_o update
// Macro MEDIAN_SIGMA_EN enables the scaled sigma path (see median_sar_lane).
module median_threshold_search
  import median_pkg::*;
#(
  parameter  int unsigned ADC_WIDTH       = 14,
  parameter  int unsigned MAX_WINDOW_SIZE = 1024,
  parameter  int unsigned LANES           = LANES_DEFAULT,
  localparam int unsigned CNT_W           = cnt_width(MAX_WINDOW_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_W-2:0]           window_size_cfg,
  input  logic                       count_valid_i,
  input  logic [LANES*CNT_W-1:0]     count_i,
  output logic [LANES*ADC_WIDTH-1:0] level_o,
  output logic                       search_en_o,
  output logic                       busy_o,
  output logic [LANES*ADC_WIDTH-1:0] median_o,
  output logic [LANES*ADC_WIDTH-1:0] sigma_o,
  output logic                       median_valid_o
);

  localparam int unsigned BIT_W = $clog2(ADC_WIDTH);

  state_t           state;
  logic [BIT_W-1:0] bit_idx;
  logic [CNT_W-1:0] rank_k;
  logic             init_c;
  logic             capture_c;
  logic             update_c;
  logic             last_c;

  assign init_c    = (state == IDLE) && start;
  assign capture_c = (state == MEASURE) && count_valid_i;
  assign update_c  = (state == UPDATE);
  assign last_c    = (bit_idx == '0);

  // Shared search sequencer and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_idx        <= '0;
      rank_k         <= '0;
      search_en_o    <= 1'b0;
      busy_o         <= 1'b0;
      median_valid_o <= 1'b0;
    end else begin
      median_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rank_k      <= (CNT_W'(window_size_cfg) + CNT_W'(2)) >> 1;
            bit_idx     <= BIT_W'(ADC_WIDTH - 1);
            busy_o      <= 1'b1;
            search_en_o <= 1'b1;
            state       <= DISCARD;
          end
        end
        // First window after a level change straddles two levels.
        DISCARD: begin
          if (count_valid_i) state <= MEASURE;
        end
        MEASURE: begin
          if (count_valid_i) state <= UPDATE;
        end
        UPDATE: begin
          if (last_c) begin
            busy_o         <= 1'b0;
            median_valid_o <= 1'b1;
            state          <= DONE;
          end else begin
            bit_idx <= bit_idx - BIT_W'(1);
            state   <= DISCARD;
          end
        end
        DONE: begin
          search_en_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    median_sar_lane #(
      .ADC_WIDTH (ADC_WIDTH),
      .CNT_W     (CNT_W),
      .BIT_W     (BIT_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .init    (init_c),
      .capture (capture_c),
      .update  (update_c),
      .last    (last_c),
      .bit_idx (bit_idx),
      .rank_k  (rank_k),
      .count   (count_i[l*CNT_W +: CNT_W]),
      .level   (level_o[l*ADC_WIDTH +: ADC_WIDTH]),
      .median  (median_o[l*ADC_WIDTH +: ADC_WIDTH]),
      .sigma   (sigma_o[l*ADC_WIDTH +: ADC_WIDTH])
    );
  end

endmodule

// File: doc/median_threshold_search.md
# median_threshold_search

Successive-approximation controller on the consuming side of the per-window median counter bank. It drives a per-lane trial level into the counters and reads back the per-lane "samples below level" counts at each window end. It then bisects each lane independently over ADC_WIDTH iterations to find the per-lane median magnitude. The final medians, plus optional noise-sigma estimates, feed the wavelet denoising threshold stage.

## Interface
- ADC_WIDTH, 14, sample magnitude width; also the number of SAR iterations.
- MAX_WINDOW_SIZE, 1024, maximum window length; CNT_W = $clog2(MAX_WINDOW_SIZE)+1.
- LANES, 8, number of independent lanes.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a search; honoured only in IDLE.
- window_size_cfg  in  CNT_W-1  window length minus one; latched on an accepted start.
- count_valid_i  in  1  one-cycle pulse at each counter-bank window end.
- count_i  in  LANES*CNT_W  per lane, number of window samples strictly below level_o for that lane; lane k occupies [k*CNT_W +: CNT_W].
- level_o  out  LANES*ADC_WIDTH  per-lane trial level driven to the counters.
- search_en_o  out  1  enables the counter bank; high in every non-IDLE state.
- busy_o  out  1  high from the cycle after an accepted start until median_valid_o.
- median_o  out  LANES*ADC_WIDTH  per-lane median; holds until the next median_valid_o.
- sigma_o  out  LANES*ADC_WIDTH  per-lane noise-sigma estimate (see Configuration).
- median_valid_o  out  1  one-cycle pulse when median_o and sigma_o update.

## Operation
- Reset values: level_o=0, search_en_o=0, busy_o=0, median_o=0, sigma_o=0, median_valid_o=0, state IDLE.
- Derived quantities: window length N = window_size_cfg+1. Rank K = (window_size_cfg+2)>>1 (ceil(N/2)), computed at CNT_W bits.
- FSM states: IDLE, DISCARD, MEASURE, UPDATE, DONE.
- IDLE, on start:
  - latch the config and compute K;
  - clear each lane result to 0;
  - set bit index b = ADC_WIDTH-1;
  - set level_o[lane] = result | (1<<b);
  - go to DISCARD.
- DISCARD: the first count_valid_i after a level change covers a mixed-level window. Ignore it and go to MEASURE.
- MEASURE: on count_valid_i, capture count_i and go to UPDATE.
- UPDATE, per lane:
  - if captured count < K, set result bit b; otherwise leave it clear.
  - If b==0, go to DONE.
  - Otherwise decrement b, set level_o = new result | (1<<b), and go to DISCARD.
- DONE:
  - median_o = result and sigma_o = computed estimate;
  - pulse median_valid_o;
  - set level_o=0;
  - return to IDLE.
- Result: the K-th smallest sample magnitude per lane. A lane whose samples are all 0 returns 0. A lane whose samples are all full scale returns 2^ADC_WIDTH-1.
- Ignored inputs:
  - start outside IDLE, including in the same cycle as DONE;
  - count_valid_i in IDLE, UPDATE and DONE.
- reset in any state returns all outputs to their reset values the next cycle. Partial results are discarded.
- window_size_cfg changes during a search have no effect.

## Timing
- start at cycle T: busy_o and search_en_o are high and level_o holds the first trial from T+1.
- Each iteration consumes exactly two count_valid_i pulses, plus one UPDATE cycle.
- median_valid_o asserts 2 cycles after the last MEASURE capture (UPDATE, then DONE). busy_o drops in the same cycle.
- Minimum total latency is about 2*ADC_WIDTH*N clocks.
- level_o changes only on UPDATE→DISCARD transitions; it is stable throughout every measured window.

## Configuration
- MEDIAN_SIGMA_EN defined:
  - sigma_o = (median*24290)>>14, approximately median/0.6745;
  - product computed at ADC_WIDTH+15 bits;
  - saturated to 2^ADC_WIDTH-1;
  - registered in DONE alongside median_o.
- MEDIAN_SIGMA_EN undefined: sigma_o = median_o, with the same timing; no multiplier is synthesised.

## Structure
- Package median_pkg holds:
  - the state enum;
  - LANES default;
  - SIGMA_MULT=24290 and SIGMA_SHIFT=14;
  - a CNT_W helper function.
- Sub-module median_sar_lane holds one lane's result register, the trial-level mux, the K compare and the optional sigma path. The top instantiates LANES copies plus the shared FSM and bit index.

## Test plan
- Constant 100 on lane 0, window_size_cfg=3 → median_o[0]=100; sigma_o[0]=148 with MEDIAN_SIGMA_EN, 100 without.
- Lane 1 repeating {5,9,2,7}, window_size_cfg=3 (K=2) → median_o[1]=5. Each lane independent with distinct data.
- Lane 2 constant 16383 → median_o[2]=16383; with MEDIAN_SIGMA_EN, sigma_o[2] saturates to 16383. All-zero lane → 0.
- start pulsed again mid-search → ignored; the original result is delivered with exactly one median_valid_o.
- reset asserted during iteration 5 → next cycle all outputs 0 and state IDLE; a fresh start yields the correct median.
- Counter model emitting count_valid_i during UPDATE → pulse ignored; the level is stable across every window used for a decision (checked by assertion).
